kogge_stone_pipe: RTL and testbench
===================================

// Module: kogge_stone_pipe
// PURPOSE
// - Pipelined, parametrised successor of the 32-bit Kogge-Stone adder: WIDTH-bit add/sub, parallel-prefix carry tree.
// - Registers are inserted every LVLS_PER_STAGE prefix levels, with a valid/ready handshake on both sides.
// - Sits between operand sources (ALU issue, accumulator paths) and any consumer that can apply backpressure.
// PARAMETERS
// - WIDTH           32  operand/sum width; power of two, 4..64
// - LVLS_PER_STAGE  2   prefix levels per pipeline stage; 1..log2(WIDTH)
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      operand beat valid
// - in_ready   out  1      block can accept a beat this cycle
// - A          in   WIDTH  operand A
// - B          in   WIDTH  operand B
// - Cin        in   1      carry-in; ignored when SUB=1
// - SUB        in   1      1: compute A + ~B + 1
// - out_valid  out  1      result beat valid
// - out_ready  in   1      consumer accepts the result this cycle
// - S          out  WIDTH  sum/difference
// - Cout       out  1      carry-out; for SUB, 1 means no borrow
// - V          out  1      signed overflow; present only with KS_OVF_EN
// BEHAVIOUR
// - NLVL = log2(WIDTH). NSTG = ceil(NLVL/LVLS_PER_STAGE).
// - LATENCY = NSTG + 1 cycles: an input-capture stage, then NSTG prefix stages.
// - The sum XOR and Cout sit in the final stage. All outputs are registered.
// - Stage 0 captures A, B_eff = SUB ? ~B : B, c0 = SUB ? 1 : Cin. It forms g=A&B_eff and p=A^B_eff.
//   - c0 folds into bit 0: g0' = g0 | (p0 & c0).
// - Prefix level k (distance 2^k) for bit i >= 2^k:
//   - G = G[i] | P[i] & G[i-2^k]
//   - P = P[i] & P[i-2^k]
//   - Bits i < 2^k pass through unchanged. The original p vector travels with the beat.
// - Final stage:
//   - S[0] = p0 ^ c0
//   - S[i] = p[i] ^ G[i-1]
//   - Cout = G[WIDTH-1]
// - Handshake uses a single global advance: adv = ~out_valid | out_ready.
//   - in_ready = adv, combinational. in_valid must not depend on in_ready.
//   - Accept happens when in_valid & in_ready.
//   - Output transfer happens when out_valid & out_ready.
//   - When adv=0, every stage register, every valid bit and out_* hold. Bubbles do not collapse.
//   - When adv=1, each stage's valid bit shifts forward. Stage 0 valid <= in_valid.
// - Throughput: 1 beat/cycle while out_ready=1.
// - Beats leave in acceptance order. No beat is dropped or duplicated.
// - Simultaneous accept and output transfer in the same cycle is legal and required.
// - Outputs of a beat stay stable while out_valid=1 & out_ready=0.
// - Reset:
//   - On rst=1 at an edge, all valid bits clear, out_valid=0, S=0, Cout=0, V=0.
//   - in_ready=1 from the first cycle after reset.
//   - Reset mid-operation discards all in-flight beats.
//   - Data registers other than the outputs need no reset.
// - Arithmetic is modulo 2^WIDTH, unsigned wrap-around.
// - LVLS_PER_STAGE >= NLVL gives a single prefix stage, so LATENCY=2.
// CONFIGURATION
// - KS_OVF_EN defined:
//   - Port V exists.
//   - V = (A[W-1] == B_eff[W-1]) & (S[W-1] != A[W-1]).
//   - The MSBs of A and B_eff are pipelined alongside the beat.
//   - V resets to 0 and holds under stall like S.
// - KS_OVF_EN undefined: port V and its registers are absent. All other behaviour is identical.
// TESTING
// - Defaults, SUB=0, Cin=0, A=15, B=10, out_ready=1 -> 4 cycles later S=25, Cout=0, out_valid=1 for 1 cycle.
// - A=32'hFFFF_FFFF, B=0, Cin=1 -> S=0, Cout=1 (full carry ripple across all levels).
// - SUB=1, A=5, B=7 -> S=32'hFFFF_FFFE, Cout=0; then A=7, B=5 -> S=2, Cout=1.
// - 6 beats back-to-back, out_ready held 0 for 5 cycles mid-stream:
//   - in_ready=0 while stalled, outputs hold, in-order results, no loss.
// - rst asserted with 3 beats in flight -> next cycle out_valid=0, S=0; first new beat appears at LATENCY.
// - KS_OVF_EN: A=32'h7FFF_FFFF, B=1 -> V=1; SUB=1, A=32'h8000_0000, B=1 -> V=1; A=1, B=1 -> V=0.

Source files
------------

// File: rtl/kogge_stone_pipe.sv
`default_nettype none
// ============================================================================
// kogge_stone_pipe : pipelined WIDTH-bit Kogge-Stone add/sub, valid/ready I/O
// Optional macro KS_OVF_EN adds the signed-overflow output V.  Rev 1.0
// ============================================================================
module kogge_stone_pipe #(
  parameter int WIDTH          = 32,
  parameter int LVLS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef KS_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int               c_nlvl = $clog2(WIDTH);
  localparam int               c_nstg = (c_nlvl + LVLS_PER_STAGE - 1) / LVLS_PER_STAGE;
  localparam int               c_last = c_nstg - 1;
  localparam logic [WIDTH-1:0] c_ones = '1;

  logic             w_adv;
  logic [WIDTH-1:0] w_beff, w_g0, w_p0, w_sum;
  logic             w_c0;

  // Index s holds the beat that has passed the capture stage and s prefix stages.
  logic             r_vld [c_nstg];
  logic [WIDTH-1:0] r_g   [c_nstg];
  logic [WIDTH-1:0] r_p   [c_nstg];
  logic [WIDTH-1:0] r_po  [c_nstg];
  logic             r_c0  [c_nstg];
  logic [WIDTH-1:0] w_gn  [c_nstg];
  logic [WIDTH-1:0] w_pn  [c_nstg];

  logic             r_ovld, r_cout;
  logic [WIDTH-1:0] r_s;

`ifdef KS_OVF_EN
  logic             r_am [c_nstg];
  logic             r_bm [c_nstg];
  logic             r_v;
  logic             w_ovf;
`endif

  assign w_adv    = ~r_ovld | out_ready;
  assign in_ready = w_adv;

  assign w_beff = SUB ? ~B : B;
  assign w_c0   = SUB | Cin;
  assign w_g0   = A & w_beff;
  assign w_p0   = A ^ w_beff;

  // Stage s applies the prefix levels k with k / LVLS_PER_STAGE == s.
  always_comb begin
    for (int s = 0; s < c_nstg; s++) begin
      w_gn[s] = r_g[s];
      w_pn[s] = r_p[s];
      for (int k = 0; k < c_nlvl; k++) begin
        if (k / LVLS_PER_STAGE == s) begin
          w_gn[s] = w_gn[s] | (w_pn[s] & (w_gn[s] << (1 << k)));
          w_pn[s] = w_pn[s] & ((w_pn[s] << (1 << k)) | ~(c_ones << (1 << k)));
        end
      end
    end
  end

  assign w_sum = r_po[c_last] ^ {w_gn[c_last][WIDTH-2:0], r_c0[c_last]};

`ifdef KS_OVF_EN
  assign w_ovf = (r_am[c_last] == r_bm[c_last]) & (w_sum[WIDTH-1] != r_am[c_last]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < c_nstg; s++) r_vld[s] <= 1'b0;
      r_ovld <= 1'b0;
      r_s    <= '0;
      r_cout <= 1'b0;
`ifdef KS_OVF_EN
      r_v    <= 1'b0;
`endif
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      if (in_valid) begin
        r_g[0]  <= {w_g0[WIDTH-1:1], w_g0[0] | (w_p0[0] & w_c0)};
        r_p[0]  <= w_p0;
        r_po[0] <= w_p0;
        r_c0[0] <= w_c0;
`ifdef KS_OVF_EN
        r_am[0] <= A[WIDTH-1];
        r_bm[0] <= w_beff[WIDTH-1];
`endif
      end
      // Data only moves with a valid beat so held outputs are never disturbed by bubbles.
      for (int s = 1; s < c_nstg; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) begin
          r_g[s]  <= w_gn[s-1];
          r_p[s]  <= w_pn[s-1];
          r_po[s] <= r_po[s-1];
          r_c0[s] <= r_c0[s-1];
`ifdef KS_OVF_EN
          r_am[s] <= r_am[s-1];
          r_bm[s] <= r_bm[s-1];
`endif
        end
      end
      r_ovld <= r_vld[c_last];
      if (r_vld[c_last]) begin
        r_s    <= w_sum;
        r_cout <= w_gn[c_last][WIDTH-1];
`ifdef KS_OVF_EN
        r_v    <= w_ovf;
`endif
      end
    end
  end

  assign out_valid = r_ovld;
  assign S         = r_s;
  assign Cout      = r_cout;
`ifdef KS_OVF_EN
  assign V         = r_v;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kogge_stone_pipe.sv
`default_nettype none
// ============================================================================
// tb_kogge_stone_pipe : directed self-checking bench for kogge_stone_pipe
// Default parameters (WIDTH=32, LVLS_PER_STAGE=2, LATENCY=4).  Rev 1.0
// ============================================================================
module tb_kogge_stone_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        cout;
  logic        v;

  int total;
  int bad;

  kogge_stone_pipe #(.WIDTH(32), .LVLS_PER_STAGE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .SUB       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (s),
    .Cout      (cout)
`ifdef KS_OVF_EN
    ,
    .V         (v)
`endif
  );

`ifndef KS_OVF_EN
  assign v = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated beat: checks latency, value and single-cycle out_valid.
  task automatic send_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [31:0] es, input logic ec, input logic ev);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    chk({tag, "_inrdy"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk({tag, "_early"}, 64'(out_valid), 64'd0);
    step();
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_s"}, 64'(s), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef KS_OVF_EN
    chk({tag, "_v"}, 64'(v), 64'(ev));
`else
    if (ev) begin end
`endif
    step();
    chk({tag, "_once"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] sa [6];
  logic [31:0] sb [6];
  logic        ss [6];
  logic [31:0] es [6];
  logic        ec [6];
  int          tx, rx;
  logic        fire_in;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_vld", 64'(out_valid), 64'd0);
    chk("reset_s", 64'(s), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    chk("reset_v", 64'(v), 64'd0);
    chk("reset_inrdy", 64'(in_ready), 64'd1);

    send_one("add15_10", 32'd15, 32'd10, 1'b0, 1'b0, 32'd25, 1'b0, 1'b0);
    send_one("ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    send_one("sub5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send_one("sub7_5", 32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0);
    send_one("msbwrap", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    send_one("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send_one("ovf_sub", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    send_one("noovf", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);

    // Back-to-back stream with a 5-cycle consumer stall in the middle.
    sa[0] = 32'd1;         sb[0] = 32'd2;    ss[0] = 1'b0; es[0] = 32'd3;         ec[0] = 1'b0;
    sa[1] = 32'h10;        sb[1] = 32'h20;   ss[1] = 1'b0; es[1] = 32'h30;        ec[1] = 1'b0;
    sa[2] = 32'hFFFF_FFF0; sb[2] = 32'h20;   ss[2] = 1'b0; es[2] = 32'h10;        ec[2] = 1'b1;
    sa[3] = 32'd1000;      sb[3] = 32'd2000; ss[3] = 1'b0; es[3] = 32'd3000;      ec[3] = 1'b0;
    sa[4] = 32'd9;         sb[4] = 32'd4;    ss[4] = 1'b1; es[4] = 32'd5;         ec[4] = 1'b1;
    sa[5] = 32'd0;         sb[5] = 32'd1;    ss[5] = 1'b1; es[5] = 32'hFFFF_FFFF; ec[5] = 1'b0;
    tx = 0; rx = 0;
    a = sa[0]; b = sb[0]; sub = ss[0]; cin = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      #1;
      fire_in = in_valid & in_ready;
      if (!out_ready) begin
        chk("stall_inrdy", 64'(in_ready), 64'd0);
        chk("stall_hold_vld", 64'(out_valid), 64'd1);
        chk("stall_hold_s", 64'(s), 64'(es[rx]));
      end else if (out_valid) begin
        chk("stream_s", 64'(s), 64'(es[rx]));
        chk("stream_cout", 64'(cout), 64'(ec[rx]));
        rx++;
      end
      step();
      if (fire_in) begin
        tx++;
        if (tx < 6) begin
          a = sa[tx]; b = sb[tx]; sub = ss[tx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    chk("stream_count", 64'(rx), 64'd6);
    chk("stream_sent", 64'(tx), 64'd6);

    // Reset with three beats in flight discards them.
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      a = 32'd100 + 32'(i); b = 32'd1; sub = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_vld", 64'(out_valid), 64'd0);
    chk("midrst_s", 64'(s), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrst_ghost", 64'(out_valid), 64'd0);
    end
    send_one("postrst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
